// File: rtl/pipe_pkg.sv
// Shared control-word layout, opcodes, FSM encoding and bubble constant
// for the 5-stage pipeline control path.
package pipe_pkg;

  localparam int CW_W = 9;

  // ID/EX word: {RegDst, Branch, MemRead, MemtoReg, ALUop[1:0], MemWrite, ALUsrc, RegWrite}
  localparam int C_REGDST   = 8;
  localparam int C_BRANCH   = 7;
  localparam int C_MEMREAD  = 6;
  localparam int C_MEMTOREG = 5;
  localparam int C_ALUOP_HI = 4;
  localparam int C_ALUOP_LO = 3;
  localparam int C_MEMWRITE = 2;
  localparam int C_ALUSRC   = 1;
  localparam int C_REGWRITE = 0;

  // EX/MEM word: {Branch, MemRead, MemtoReg, MemWrite, RegWrite}
  localparam int M_BRANCH   = 4;
  localparam int M_MEMREAD  = 3;
  localparam int M_MEMTOREG = 2;
  localparam int M_MEMWRITE = 1;
  localparam int M_REGWRITE = 0;

  localparam logic [5:0] OP_R_FORMAT = 6'b000000;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;
  localparam logic [5:0] OP_BNE      = 6'b000101;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [CW_W-1:0] CTRL_NOP = '0;

  function automatic logic [4:0] ex2mem(input logic [CW_W-1:0] c);
    return {c[C_BRANCH], c[C_MEMREAD], c[C_MEMTOREG], c[C_MEMWRITE], c[C_REGWRITE]};
  endfunction

endpackage

// File: rtl/pipe_ctrl_sched_hazard_detect.sv
// Combinational hazard evaluation with priority freeze > taken > load-use;
// taken and lu outputs are already masked by higher-priority events.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_branch,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_ne,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             mem_ready,
  output logic             freeze,
  output logic             taken,
  output logic             lu
);

  logic taken_raw, lu_raw;

  always_comb begin
    freeze    = (mem_rd | mem_wr) & ~mem_ready;
    taken_raw = ex_branch & ex_ne;
    // $0 is hardwired, so a load into it never creates a dependency
    lu_raw    = ex_memread & id_valid & (ex_wreg != '0) &
                ((ex_wreg == id_rs) | (ex_wreg == id_rt));
    taken     = taken_raw & ~freeze;
    lu        = lu_raw & ~freeze & ~taken_raw;
  end

endmodule

// File: rtl/pipe_ctrl_sched.sv
// Pipeline control scheduler: carries decoded control through ID/EX, EX/MEM,
// MEM/WB and applies bubbles, branch flushes and memory freezes.
module pipe_ctrl_sched
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic [CW_W-1:0]  id_ctrl,
  input  logic             ex_ne,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CW_W-1:0]  ex_ctrl,
  output logic [REG_W-1:0] ex_wreg,
  output logic [4:0]       mem_ctrl,
  output logic [REG_W-1:0] mem_wreg,
  output logic [1:0]       wb_ctrl,
  output logic [REG_W-1:0] wb_wreg,
  output logic             stall,
  output logic             freeze,
  output logic             mem_timeout
);

  localparam logic [3:0] WMAX = 4'(WAIT_MAX);

  logic [CW_W-1:0]  ex_ctrl_q, ex_ctrl_d;
  logic [REG_W-1:0] ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic [4:0]       mem_ctrl_q, mem_ctrl_d;
  logic [REG_W-1:0] mem_wreg_q, mem_wreg_d;
  logic [1:0]       wb_ctrl_q, wb_ctrl_d;
  logic [REG_W-1:0] wb_wreg_q, wb_wreg_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       state_q, state_d;

  logic hz_freeze, hz_taken, hz_lu;

  assign ex_wreg = ex_ctrl_q[C_REGDST] ? ex_rd_q : ex_rt_q;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_branch  (ex_ctrl_q[C_BRANCH]),
    .ex_memread (ex_ctrl_q[C_MEMREAD]),
    .ex_wreg    (ex_wreg),
    .ex_ne      (ex_ne),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .mem_rd     (mem_ctrl_q[M_MEMREAD]),
    .mem_wr     (mem_ctrl_q[M_MEMWRITE]),
    .mem_ready  (mem_ready),
    .freeze     (hz_freeze),
    .taken      (hz_taken),
    .lu         (hz_lu)
  );

  // Front-end enables fall back to free-running fetch while reset is held
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    pc_src     = 1'b0;
    ifid_flush = 1'b0;
    stall      = 1'b0;
    freeze     = 1'b0;
    if (rst_n) begin
      freeze     = hz_freeze;
      stall      = hz_lu;
      pc_src     = hz_taken;
      ifid_flush = hz_taken;
      pc_write   = ~hz_freeze & ~hz_lu;
      ifid_write = ~hz_freeze & ~hz_lu;
    end
  end

  always_comb begin
    ex_ctrl_d  = ex_ctrl_q;
    ex_rt_d    = ex_rt_q;
    ex_rd_d    = ex_rd_q;
    mem_ctrl_d = mem_ctrl_q;
    mem_wreg_d = mem_wreg_q;
    wb_ctrl_d  = wb_ctrl_q;
    wb_wreg_d  = wb_wreg_q;
    wcnt_d     = wcnt_q;
    timeout_d  = timeout_q;
    if (hz_freeze) begin
      wcnt_d = (wcnt_q == WMAX) ? wcnt_q : wcnt_q + 4'd1;
      if (wcnt_d == WMAX) timeout_d = 1'b1;
    end else begin
      wcnt_d     = '0;
      wb_ctrl_d  = {mem_ctrl_q[M_MEMTOREG], mem_ctrl_q[M_REGWRITE]};
      wb_wreg_d  = mem_wreg_q;
      mem_ctrl_d = ex2mem(ex_ctrl_q);
      mem_wreg_d = ex_wreg;
      if (hz_taken || hz_lu || !id_valid) begin
        ex_ctrl_d = CTRL_NOP;
        ex_rt_d   = '0;
        ex_rd_d   = '0;
      end else begin
        ex_ctrl_d = id_ctrl;
        ex_rt_d   = id_rt;
        ex_rd_d   = id_rd;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   state_d = hz_freeze ? ST_WAIT : (hz_lu ? ST_STALL : ST_RUN);
      ST_STALL: state_d = hz_freeze ? ST_WAIT : ST_RUN;
      ST_WAIT:  state_d = mem_ready ? ST_RUN : ST_WAIT;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_q  <= CTRL_NOP;
      ex_rt_q    <= '0;
      ex_rd_q    <= '0;
      mem_ctrl_q <= '0;
      mem_wreg_q <= '0;
      wb_ctrl_q  <= '0;
      wb_wreg_q  <= '0;
      wcnt_q     <= '0;
      timeout_q  <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rt_q    <= ex_rt_d;
      ex_rd_q    <= ex_rd_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_wreg_q <= mem_wreg_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_wreg_q  <= wb_wreg_d;
      wcnt_q     <= wcnt_d;
      timeout_q  <= timeout_d;
      state_q    <= state_d;
    end
  end

  assign ex_ctrl     = ex_ctrl_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign mem_wreg    = mem_wreg_q;
  assign wb_ctrl     = wb_ctrl_q;
  assign wb_wreg     = wb_wreg_q;
  assign mem_timeout = timeout_q;

endmodule

// File: doc/pipe_ctrl_sched.md
Name: pipe_ctrl_sched

Overview:
- Pipeline control scheduler for the 5-stage MIPS core.
- Takes the decoded control word from the combinational control decoder (ID stage) and carries it through the ID/EX, EX/MEM and MEM/WB control registers.
- Inserts bubbles on load-use hazards, flushes on a taken bne resolved in EX, and freezes the whole pipeline while data memory is not ready.
- Drives PC and IF/ID write enables and supplies per-stage control bits to the datapath.

Parameters:
- WAIT_MAX, 15, max consecutive freeze cycles before mem_timeout is set.
- REG_W, 5, register specifier width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_rd  in  5  ID destination register rd
- id_ctrl  in  9  {RegDst, Branch, MemRead, MemtoReg, ALUop[1:0], MemWrite, ALUsrc, RegWrite} from decoder
- ex_ne  in  1  EX comparator result, operands not equal
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC load enable
- pc_src  out  1  select branch target
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads NOP
- ex_ctrl  out  9  ID/EX control register
- ex_wreg  out  5  EX destination (RegDst ? rd : rt)
- mem_ctrl  out  5  {Branch, MemRead, MemtoReg, MemWrite, RegWrite}
- mem_wreg  out  5  EX/MEM destination
- wb_ctrl  out  2  {MemtoReg, RegWrite}
- wb_wreg  out  5  MEM/WB destination
- stall  out  1  load-use bubble inserted this cycle
- freeze  out  1  pipeline held for memory
- mem_timeout  out  1  sticky error

Behaviour:
- Reset (rst_n=0 at clk edge): all control registers, wreg registers, counter and mem_timeout go to 0; FSM goes to RUN.
- During reset, combinational outputs are pc_write=1, ifid_write=1, pc_src=0, ifid_flush=0.
- ID/EX also stores rt and rd; ex_wreg is combinational from them.
- freeze = mem_ctrl.MemRead|mem_ctrl.MemWrite, and !mem_ready.
- taken = ex_ctrl.Branch & ex_ne.
- lu = ex_ctrl.MemRead & id_valid & ex_wreg!=0 & (ex_wreg==id_rs | ex_wreg==id_rt).
- Priority is freeze > taken > lu.
- On freeze:
  - all stage registers hold; pc_write=0, ifid_write=0, pc_src=0, ifid_flush=0.
  - A pending branch or hazard is re-evaluated after the freeze releases.
- On taken (not frozen):
  - pc_src=1, pc_write=1, ifid_flush=1.
  - ID/EX loads a bubble (all zero); EX/MEM and MEM/WB advance normally.
  - A simultaneous lu is ignored.
- On lu (not frozen, not taken):
  - pc_write=0, ifid_write=0, stall=1; ID/EX loads a bubble; EX/MEM and MEM/WB advance.
  - Exactly one bubble per load-use pair.
- Otherwise, ID/EX captures id_ctrl when id_valid=1, or a bubble when id_valid=0. EX/MEM and MEM/WB shift.
- FSM states:
  - RUN: normal operation.
  - STALL: entered for one cycle after lu.
  - WAIT: entered while freeze=1.
- FSM transitions:
  - RUN→WAIT on freeze; RUN→STALL on lu; STALL→RUN unconditionally unless freeze (then WAIT).
  - WAIT→RUN when mem_ready=1.
  - In STALL, lu cannot re-fire because the bubble cleared ex_ctrl.MemRead.
- Wait counter:
  - 4 bits; increments each WAIT cycle, saturates at WAIT_MAX.
  - Cleared on WAIT exit.
  - Reaching WAIT_MAX sets mem_timeout, which stays set until reset.
- Reset mid-freeze or mid-stall: everything returns to the reset state on that edge.
- A destination of register 0 never causes a stall.

Decomposition:
- Shared package pipe_pkg holds:
  - the 9-bit control-word field index constants;
  - the opcodes R_FORMAT=000000, LW=100011, SW=101011, BNE=000101;
  - the FSM state encoding (RUN=0, STALL=1, WAIT=2);
  - the NOP/bubble constant.
- One natural sub-module: hazard_detect, combinational lu/taken/freeze logic with priority resolution.

Test Plan:
- lw $2 (ex_ctrl=lw word, ex_wreg=2) followed by id_rs=2 → one cycle with stall=1, pc_write=0, ifid_write=0, ex_ctrl=0 next edge. The next cycle has stall=0.
- bne in EX with ex_ne=1 and lu also true → pc_src=1, ifid_flush=1, stall=0, ex_ctrl bubble. With ex_ne=0 → no flush.
- sw in MEM, mem_ready low 3 cycles → freeze=1 for 3 cycles, all *_ctrl/*_wreg constant, pc_write=0. Advances on the 4th cycle.
- mem_ready held low 16 cycles → mem_timeout=1 after WAIT_MAX=15 cycles and stays 1 after mem_ready rises. Cleared only by rst_n=0.
- R-format, lw, sw, bne sequence with no hazards → control words appear at ex/mem/wb 1, 2 and 3 cycles after ID. wb_ctrl for lw is 2'b11, for R-format 2'b01, for sw 2'b00.
- rst_n=0 asserted during WAIT → next edge has all outputs zero, FSM in RUN, pc_write=1.
